// File: rtl/spi_frame_collector.sv
// -----------------------------------------------------------------------------
// spi_frame_collector
//
// Collects three consecutive bytes delivered by an SPI reader stage into one
// frame (ch0, ch1, ch2 in arrival order) and hands it downstream with a
// valid/ready handshake. A partial frame is discarded if the next byte does
// not arrive within IDLE_TIMEOUT clk cycles.
//
// Optional feature: define SPI_FRAME_CKSUM_EN to add the cksum output
// (ch0 ^ ch1 ^ ch2, registered together with the frame).
//
// Parameters
//   IDLE_TIMEOUT  clk cycles allowed between bytes of one frame (default 1024)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cs_in      in   chip select from the reader (async); rising edge = byte done
//   din[7:0]   in   byte from the reader, stable while cs_in is high
//   frm_ready  in   downstream accepts the frame when high with frm_valid
//   ovf_clr    in   one-cycle clear of the sticky overflow flag
//   frm_valid  out  ch0..ch2 hold a complete frame
//   ch0..ch2   out  frame bytes in arrival order
//   ovf        out  sticky: a completed frame was dropped
//   tmo        out  one-cycle pulse: a partial frame was discarded on timeout
//   cksum[7:0] out  (SPI_FRAME_CKSUM_EN only) XOR of the frame bytes
// -----------------------------------------------------------------------------
module spi_frame_collector #(
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_in,
    input  logic [7:0] din,
    input  logic       frm_ready,
    input  logic       ovf_clr,
    output logic       frm_valid,
    output logic [7:0] ch0,
    output logic [7:0] ch1,
    output logic [7:0] ch2,
    output logic       ovf,
`ifdef SPI_FRAME_CKSUM_EN
    output logic [7:0] cksum,
`endif
    output logic       tmo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2
    } state_t;

    // Last idle-count value before the timeout fires: the partial frame is
    // dropped once IDLE_TIMEOUT event-free cycles have elapsed.
    localparam logic [15:0] TMO_LAST = 16'(IDLE_TIMEOUT - 1);

    state_t      r_state;
    logic        r_cs_meta;
    logic        r_cs_sync;
    logic        r_cs_prev;
    logic [15:0] r_idle;
    logic [7:0]  r_slot0;
    logic [7:0]  r_slot1;
    logic        r_frm_valid;
    logic [7:0]  r_ch0;
    logic [7:0]  r_ch1;
    logic [7:0]  r_ch2;
    logic        r_ovf;
    logic        r_tmo;
`ifdef SPI_FRAME_CKSUM_EN
    logic [7:0]  r_cksum;
`endif

    logic w_evt;
    logic w_complete;
    logic w_accept;
    logic w_load;
    logic w_drop;

    // Synchronizer flops reset to 1, so a cs_in held high out of reset never
    // looks like an edge: an event needs a low cycle seen first.
    assign w_evt      = r_cs_sync & ~r_cs_prev;
    assign w_complete = w_evt & (r_state == B2);
    assign w_accept   = r_frm_valid & frm_ready;
    assign w_load     = w_complete & (~r_frm_valid | frm_ready);
    assign w_drop     = w_complete & r_frm_valid & ~frm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_idle      <= '0;
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_frm_valid <= 1'b0;
            r_ch0       <= '0;
            r_ch1       <= '0;
            r_ch2       <= '0;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
            r_cksum     <= '0;
`endif
        end else begin
            r_cs_meta <= cs_in;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
            r_tmo     <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_idle <= '0;
                    if (w_evt) begin
                        r_slot0 <= din;
                        r_state <= B1;
                    end
                end
                B1, B2: begin
                    if (w_evt) begin
                        r_idle <= '0;
                        if (r_state == B1) begin
                            r_slot1 <= din;
                            r_state <= B2;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_idle == TMO_LAST) begin
                        r_idle  <= '0;
                        r_slot0 <= '0;
                        r_slot1 <= '0;
                        r_state <= IDLE;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 16'd1;
                    end
                end
                default: begin
                    r_idle  <= '0;
                    r_state <= IDLE;
                end
            endcase

            // Third byte goes straight from din into ch2; slots hold the first two.
            if (w_load) begin
                r_frm_valid <= 1'b1;
                r_ch0       <= r_slot0;
                r_ch1       <= r_slot1;
                r_ch2       <= din;
`ifdef SPI_FRAME_CKSUM_EN
                r_cksum     <= r_slot0 ^ r_slot1 ^ din;
`endif
            end else if (w_accept) begin
                r_frm_valid <= 1'b0;
            end

            // A drop wins over a simultaneous clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign frm_valid = r_frm_valid;
    assign ch0       = r_ch0;
    assign ch1       = r_ch1;
    assign ch2       = r_ch2;
    assign ovf       = r_ovf;
    assign tmo       = r_tmo;
`ifdef SPI_FRAME_CKSUM_EN
    assign cksum     = r_cksum;
`endif

endmodule
